// File: rtl/reaction_sequencer_pkg.sv
// Shared types and widths for the reaction-time sequencer.
// Holds the FSM state encoding and the counter/random widths.
package reaction_sequencer_pkg;

   localparam int MS_W   = 14;
   localparam int RAND_W = 10;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_DELAY,
      STIM,
      DONE
   } state_e;

endpackage

// File: rtl/reaction_sequencer_ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV clocks.
// clr restarts the count so the first tick lands TICK_DIV cycles after it.
module ms_tick_gen #(
   parameter int TICK_DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int W = $clog2(TICK_DIV);
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Tick on the last count, then wrap; clear forces a fresh period.
   always_comb begin
      tick  = (cnt_q == LAST);
      cnt_d = (clr || tick) ? '0 : cnt_q + W'(1);
   end

   // Prescaler count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/reaction_sequencer.sv
// Reaction-time trial sequencer: random foreperiod, stimulus lamp,
// measured response in ms, with false-start and timeout detection.
module reaction_sequencer
   import reaction_sequencer_pkg::*;
#(
   parameter int TICK_DIV     = 100000,
   parameter int MIN_DELAY_MS = 1000,
   parameter int TIMEOUT_MS   = 9999
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              btn,
   input  logic [RAND_W-1:0] rand_num,
   output logic              stim_led,
   output logic              busy,
   output logic              result_valid,
   output logic [MS_W-1:0]   result_ms,
   output logic              false_start,
   output logic              timeout
);

   localparam logic [MS_W-1:0] MIN_D  = MS_W'(MIN_DELAY_MS);
   localparam logic [MS_W-1:0] TO_LIM = MS_W'(TIMEOUT_MS);

   state_e          state_q;
   logic [MS_W-1:0] cnt_ms_q;
   logic [MS_W-1:0] cnt_ms_d;
   logic [MS_W-1:0] target_q;
   logic [MS_W-1:0] result_q;
   logic            btn_q;
   logic            stim_q;
   logic            busy_q;
   logic            valid_q;
   logic            fs_q;
   logic            to_q;

   logic tick;
   logic clr;
   logic rise;
   logic hit_delay;
   logic hit_to;

   ms_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .tick (tick)
   );

   // Edge detect, counter lookahead and prescaler restart on state change.
   always_comb begin
      rise      = btn & ~btn_q;
      cnt_ms_d  = cnt_ms_q + MS_W'(1);
      hit_delay = tick & (cnt_ms_d >= target_q);
      hit_to    = tick & (cnt_ms_d >= TO_LIM);
      clr       = 1'b0;
      case (state_q)
         IDLE:       clr = 1'b1;
         WAIT_DELAY: clr = rise | hit_delay;
         STIM:       clr = rise | hit_to;
         DONE:       clr = 1'b1;
         default:    clr = 1'b1;
      endcase
   end

   // Trial FSM with registered outputs; a press beats a same-cycle limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_ms_q <= '0;
         target_q <= '0;
         result_q <= '0;
         btn_q    <= 1'b0;
         stim_q   <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         fs_q     <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         btn_q   <= btn;
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  target_q <= MIN_D + MS_W'(rand_num);
                  cnt_ms_q <= '0;
                  result_q <= '0;
                  fs_q     <= 1'b0;
                  to_q     <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= WAIT_DELAY;
               end
            end
            WAIT_DELAY: begin
               if (rise) begin
                  fs_q     <= 1'b1;
                  result_q <= '0;
                  valid_q  <= 1'b1;
                  state_q  <= DONE;
               end else if (hit_delay) begin
                  cnt_ms_q <= '0;
                  stim_q   <= 1'b1;
                  state_q  <= STIM;
               end else if (tick) begin
                  cnt_ms_q <= cnt_ms_d;
               end
            end
            STIM: begin
               if (rise) begin
                  result_q <= cnt_ms_q;
                  valid_q  <= 1'b1;
                  stim_q   <= 1'b0;
                  state_q  <= DONE;
               end else if (hit_to) begin
                  result_q <= TO_LIM;
                  to_q     <= 1'b1;
                  valid_q  <= 1'b1;
                  stim_q   <= 1'b0;
                  state_q  <= DONE;
               end else if (tick) begin
                  cnt_ms_q <= cnt_ms_d;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               stim_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign stim_led     = stim_q;
   assign busy         = busy_q;
   assign result_valid = valid_q;
   assign result_ms    = result_q;
   assign false_start  = fs_q;
   assign timeout      = to_q;

endmodule
